stopwatch_run_ctrl: RTL

//  Run/mode controller for the stopwatch BCD counter datapath (SS.hh, 00.00-99.99).

---
 rtl/stopwatch_run_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/stopwatch_run_ctrl.sv
// stopwatch_run_ctrl
//   Run/mode controller for the SS.hh BCD stopwatch counter (00.00-99.99).
//   It picks the count direction and start value from the mode, loads the
//   counter, and toggles run/pause on each rising edge of the stop button.
//   While running, it issues one count-enable pulse every TICK_DIV clocks.
//   It halts in DONE once the counter reports the terminal value.
//
// Ports
//   clk, reset     rising-edge clock, synchronous active-high reset
//   clear          pulse: reload the start value for the current mode, pause
//   mode[1:0]      0 up/00.00, 1 up/preset, 2 down/99.99, 3 down/preset
//   stop           debounced button level; a rising edge toggles run/pause
//   n0, n1         preset seconds digits (ones, tens), clamped to 9
//   cnt_at_zero    counter == 00.00
//   cnt_at_max     counter == 99.99
//   cnt_load       1-cycle pulse: the counter loads cnt_load_val
//   cnt_load_val   BCD {s10,s1,h10,h1}
//   cnt_en         1-cycle pulse: the counter steps one hundredth
//   cnt_up         count direction (1 = up)
//   running, done  status flags for RUN and DONE
module stopwatch_run_ctrl #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [1:0]  mode,
  input  logic        stop,
  input  logic [3:0]  n0,
  input  logic [3:0]  n1,
  input  logic        cnt_at_zero,
  input  logic        cnt_at_max,
  output logic        cnt_load,
  output logic [15:0] cnt_load_val,
  output logic        cnt_en,
  output logic        cnt_up,
  output logic        running,
  output logic        done
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PAUSE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          stop_q;
  logic [1:0]    mode_q;
  logic          cnt_load_q, cnt_load_d;
  logic [15:0]   cnt_load_val_q, cnt_load_val_d;
  logic          cnt_en_q, cnt_en_d;
  logic          cnt_up_q, cnt_up_d;
  logic          running_q, running_d;
  logic          done_q, done_d;

  logic stop_rise, mode_chg, terminal;

  function automatic logic [3:0] clamp_digit(input logic [3:0] n);
    return (n > 4'd9) ? 4'h9 : n;
  endfunction

  always_comb begin
    stop_rise = stop & ~stop_q;
    mode_chg  = (mode != mode_q);
    // The terminal value depends on the direction that is currently loaded.
    terminal  = cnt_up_q ? cnt_at_max : cnt_at_zero;

    state_d        = state_q;
    tick_d         = '0;
    cnt_en_d       = 1'b0;
    cnt_up_d       = cnt_up_q;
    cnt_load_val_d = cnt_load_val_q;

    case (state_q)
      S_IDLE:  state_d = S_LOAD;
      S_LOAD:  state_d = S_PAUSE;
      S_PAUSE: if (stop_rise) state_d = S_RUN;
      S_RUN: begin
        if (stop_rise) begin
          state_d = S_PAUSE;
        end else if (terminal) begin
          // No pulse may be issued while the counter sits on its terminal value.
          state_d = S_DONE;
        end else begin
          tick_d   = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
          cnt_en_d = (tick_q == TICK_LAST);
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    // Clear and mode change take precedence over run/pause handling.
    // A stop edge in the same cycle is therefore dropped.
    if (state_q != S_IDLE && (clear || mode_chg)) begin
      state_d  = S_LOAD;
      tick_d   = '0;
      cnt_en_d = 1'b0;
    end

    // The live mode/preset inputs are captured on the edge that enters LOAD.
    // The value is then presented to the counter during the LOAD cycle itself.
    if (state_d == S_LOAD) begin
      cnt_up_d = ~mode[1];
      case (mode)
        2'd0:    cnt_load_val_d = 16'h0000;
        2'd2:    cnt_load_val_d = 16'h9999;
        default: cnt_load_val_d = {clamp_digit(n1), clamp_digit(n0), 8'h00};
      endcase
    end

    cnt_load_d = (state_d == S_LOAD);
    running_d  = (state_d == S_RUN);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      tick_q         <= '0;
      stop_q         <= 1'b0;
      mode_q         <= mode;
      cnt_load_q     <= 1'b0;
      cnt_load_val_q <= 16'h0000;
      cnt_en_q       <= 1'b0;
      cnt_up_q       <= 1'b0;
      running_q      <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_q         <= tick_d;
      stop_q         <= stop;
      mode_q         <= mode;
      cnt_load_q     <= cnt_load_d;
      cnt_load_val_q <= cnt_load_val_d;
      cnt_en_q       <= cnt_en_d;
      cnt_up_q       <= cnt_up_d;
      running_q      <= running_d;
      done_q         <= done_d;
    end
  end

  assign cnt_load     = cnt_load_q;
  assign cnt_load_val = cnt_load_val_q;
  assign cnt_en       = cnt_en_q;
  assign cnt_up       = cnt_up_q;
  assign running      = running_q;
  assign done         = done_q;

endmodule
